// File: rtl/latent_mac_collector_if.sv
// Handshake and lane bus between the MAC collector, its upstream buffer and the result consumer.
// Lane index 0..7 corresponds to lanes 1..8 (in_data_1..in_data_8, out_data_1..out_data_8).
interface latent_mac_collector_if;
    logic               start;
    logic               mode_req;
    logic               buf_op_mode;
    logic               buf_read_en;
    logic signed [15:0] in_data  [8];
    logic signed [15:0] weight;
    logic signed [15:0] out_data [8];
    logic               out_valid;
    logic               out_ready;
    logic               out_mode;
    logic               busy;

    modport master (
        output start, mode_req, in_data, weight, out_ready,
        input  buf_op_mode, buf_read_en, out_data, out_valid, out_mode, busy
    );

    modport slave (
        input  start, mode_req, in_data, weight, out_ready,
        output buf_op_mode, buf_read_en, out_data, out_valid, out_mode, busy
    );
endinterface

// File: rtl/latent_mac_collector.sv
// Eight-lane Q8.8 multiply-accumulate over one BEATS-deep buffer pass, results held until accepted.
// Define MAC_SAT_EN to saturate the 16-bit result instead of wrapping.
module latent_mac_collector #(
    parameter int unsigned LANES = 8,
    parameter int unsigned BEATS = 8
) (
    input logic                    clk,
    input logic                    rst,
    latent_mac_collector_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    localparam logic [2:0] LastBeat = 3'(BEATS - 1);

    state_e             r_state;
    logic [2:0]         r_beat;
    logic               r_read_en;
    logic               r_strb;
    logic               r_op_mode;
    logic               r_out_mode;
    logic               r_out_valid;
    logic               r_busy;
    logic signed [35:0] r_acc [LANES];
    logic signed [15:0] r_out [LANES];

    logic signed [31:0] w_prod [LANES];
    logic signed [35:0] w_sum  [LANES];
    logic signed [15:0] w_red  [LANES];

    always_comb begin
`ifdef MAC_SAT_EN
        logic signed [35:0] v;
        v = '0;
`endif
        for (int i = 0; i < int'(LANES); i++) begin
            w_prod[i] = 32'(bus.in_data[i]) * 32'(bus.weight);
            // Accumulate only on strobed beats so weight/data changes elsewhere are ignored.
            w_sum[i]  = r_strb ? r_acc[i] + 36'(w_prod[i]) : r_acc[i];
`ifdef MAC_SAT_EN
            v = w_sum[i] >>> 8;
            if (v > 36'sd32767) begin
                w_red[i] = 16'sh7FFF;
            end else if (v < -36'sd32768) begin
                w_red[i] = -16'sh8000;
            end else begin
                w_red[i] = v[15:0];
            end
`else
            w_red[i] = w_sum[i][23:8];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_beat      <= '0;
            r_read_en   <= 1'b0;
            r_strb      <= 1'b0;
            r_op_mode   <= 1'b0;
            r_out_mode  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < int'(LANES); i++) begin
                r_acc[i] <= '0;
                r_out[i] <= '0;
            end
        end else begin
            r_strb <= r_read_en;
            for (int i = 0; i < int'(LANES); i++) begin
                r_acc[i] <= w_sum[i];
            end
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_state   <= StFetch;
                        r_op_mode <= bus.mode_req;
                        r_read_en <= 1'b1;
                        r_beat    <= '0;
                        r_busy    <= 1'b1;
                        for (int i = 0; i < int'(LANES); i++) begin
                            r_acc[i] <= '0;
                        end
                    end
                end
                StFetch: begin
                    r_beat <= r_beat + 3'd1;
                    if (r_beat == LastBeat) begin
                        r_read_en <= 1'b0;
                        r_state   <= StDrain;
                    end
                end
                StDrain: begin
                    // Final beat lands this edge, so results come from the summed value.
                    r_state     <= StDone;
                    r_out_valid <= 1'b1;
                    r_out_mode  <= r_op_mode;
                    for (int i = 0; i < int'(LANES); i++) begin
                        r_out[i] <= w_red[i];
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.buf_op_mode = r_op_mode;
    assign bus.buf_read_en = r_read_en;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_mode    = r_out_mode;
    assign bus.busy        = r_busy;
    assign bus.out_data    = r_out;
endmodule
